// File: rtl/fmul_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : fmul_arbiter
//  Description : Round-robin front end that shares one pipelined fmul unit
//                among N_REQ requesters. One grant per cycle; the winner's
//                operands are registered into the fmul and its id rides a
//                shadow pipeline so the product is steered back to it
//                exactly LAT cycles after issue.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk         in   1         clock, all state on posedge
//    reset       in   1         synchronous, active-high
//    en          in   1         issue enable (in-flight ops always drain)
//    req_valid   in   N_REQ     request pending per requester
//    req_op1     in   32*N_REQ  operand 1, requester i at [32*i+:32]
//    req_op2     in   32*N_REQ  operand 2, same packing
//    req_ready   out  N_REQ     one-hot grant
//    resp_valid  out  N_REQ     one-hot, product for requester i this cycle
//    resp_data   out  32        product, shared by all requesters
//    mul_op1     out  32        registered operand to fmul op1
//    mul_op2     out  32        registered operand to fmul op2
//    mul_result  in   32        fmul result
//    busy        out  1         any op in flight
//    issue_cnt   out  32        issued-op count, wraps at 2^32
// ============================================================================
module fmul_arbiter #(
   parameter int  N_REQ = 4,
   parameter int  LAT   = 3,
   localparam int ID_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 en,
   input  logic [N_REQ-1:0]     req_valid,
   input  logic [32*N_REQ-1:0]  req_op1,
   input  logic [32*N_REQ-1:0]  req_op2,
   output logic [N_REQ-1:0]     req_ready,
   output logic [N_REQ-1:0]     resp_valid,
   output logic [31:0]          resp_data,
   output logic [31:0]          mul_op1,
   output logic [31:0]          mul_op2,
   input  logic [31:0]          mul_result,
   output logic                 busy,
   output logic [31:0]          issue_cnt
);

   // Last granted id; the scan starts one past it.
   logic [ID_W-1:0]  r_ptr;
   // Shadow pipeline: bit k / entry k mirror fmul stage k.
   logic [LAT:0]     r_pipe_vld;
   logic [ID_W-1:0]  r_pipe_id [0:LAT];
   logic [31:0]      r_mul_op1;
   logic [31:0]      r_mul_op2;
   logic [31:0]      r_issue_cnt;

   logic [N_REQ-1:0] w_grant;
   logic [ID_W-1:0]  w_gnt_id;
   logic [ID_W-1:0]  w_scan_id;
   logic             w_hs;

   // Round-robin scan ptr+1 .. ptr+N_REQ (mod N_REQ). A grant is only
   // raised on a valid request, so grant == handshake.
   always_comb begin
      w_grant   = '0;
      w_gnt_id  = '0;
      w_scan_id = '0;
      w_hs      = 1'b0;
      if (!reset && en) begin
         for (int k = 1; k <= N_REQ; k++) begin
            w_scan_id = ID_W'((int'(r_ptr) + k) % N_REQ);
            if (!w_hs && req_valid[w_scan_id]) begin
               w_hs               = 1'b1;
               w_gnt_id           = w_scan_id;
               w_grant[w_scan_id] = 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_ptr       <= ID_W'(N_REQ - 1);
         r_pipe_vld  <= '0;
         r_mul_op1   <= '0;
         r_mul_op2   <= '0;
         r_issue_cnt <= '0;
         for (int k = 0; k <= LAT; k++) begin
            r_pipe_id[k] <= '0;
         end
      end else begin
         // The fmul has no stall, so neither does the shadow pipe.
         r_pipe_vld   <= {r_pipe_vld[LAT-1:0], w_hs};
         r_pipe_id[0] <= w_gnt_id;
         for (int k = 1; k <= LAT; k++) begin
            r_pipe_id[k] <= r_pipe_id[k-1];
         end
         if (w_hs) begin
            r_mul_op1   <= req_op1[32*w_gnt_id +: 32];
            r_mul_op2   <= req_op2[32*w_gnt_id +: 32];
            r_ptr       <= w_gnt_id;
            r_issue_cnt <= r_issue_cnt + 32'd1;
         end
      end
   end

   // Response steering from the last shadow stage; forced quiet in reset.
   always_comb begin
      resp_valid = '0;
      if (!reset && r_pipe_vld[LAT]) begin
         resp_valid[r_pipe_id[LAT]] = 1'b1;
      end
   end

   assign req_ready = w_grant;
   assign resp_data = mul_result;
   assign mul_op1   = r_mul_op1;
   assign mul_op2   = r_mul_op2;
   assign busy      = !reset && (|r_pipe_vld);
   assign issue_cnt = r_issue_cnt;

endmodule
`default_nettype wire

// File: tb/tb_fmul_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fmul_arbiter
//  Description : Scoreboard bench for fmul_arbiter with a 3-stage fmul stand-in
//                and a round-robin reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fmul_arbiter;

   localparam int N   = 4;
   localparam int LAT = 3;

   logic            clk = 1'b0;
   logic            reset = 1'b1;
   logic            en = 1'b0;
   logic [N-1:0]    req_valid = '0;
   logic [32*N-1:0] req_op1 = '0;
   logic [32*N-1:0] req_op2 = '0;
   logic [N-1:0]    req_ready;
   logic [N-1:0]    resp_valid;
   logic [31:0]     resp_data;
   logic [31:0]     mul_op1;
   logic [31:0]     mul_op2;
   logic [31:0]     mul_result = '0;
   logic            busy;
   logic [31:0]     issue_cnt;

   fmul_arbiter #(.N_REQ(N), .LAT(LAT)) dut (
      .clk        (clk),
      .reset      (reset),
      .en         (en),
      .req_valid  (req_valid),
      .req_op1    (req_op1),
      .req_op2    (req_op2),
      .req_ready  (req_ready),
      .resp_valid (resp_valid),
      .resp_data  (resp_data),
      .mul_op1    (mul_op1),
      .mul_op2    (mul_op2),
      .mul_result (mul_result),
      .busy       (busy),
      .issue_cnt  (issue_cnt)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Truncating single-precision multiply for normal operands.
   function automatic logic [31:0] fmul_fn(input logic [31:0] a, input logic [31:0] b);
      logic [47:0] p;
      logic [9:0]  e;
      logic [22:0] m;
      p = {1'b1, a[22:0]} * {1'b1, b[22:0]};
      e = {2'b00, a[30:23]} + {2'b00, b[30:23]} - 10'd127;
      if (p[47]) begin
         e = e + 10'd1;
         m = p[46:24];
      end else begin
         m = p[45:23];
      end
      return {a[31] ^ b[31], e[7:0], m};
   endfunction

   // fmul stand-in: samples op1/op2 and updates its result LAT edges later.
   logic [31:0] f_s1 = '0, f_s2 = '0;
   always @(posedge clk) begin
      f_s1       <= fmul_fn(mul_op1, mul_op2);
      f_s2       <= f_s1;
      mul_result <= f_s2;
   end

   typedef struct {
      int          id;
      logic [31:0] data;
      int          due;
   } exp_t;

   exp_t        sb[$];
   int          n_cmp = 0;
   int          n_bad = 0;
   int          m_ptr = N - 1;
   logic [31:0] m_cnt = '0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s @cyc %0d: got %h expected %h", name, cyc, act, exp);
      end
   endtask

   // One cycle of stimulus: drive at negedge, check the grant, then update
   // the model at the following posedge.
   task automatic drive(input logic rst_v, input logic en_v, input logic [N-1:0] vld_v,
                        input logic rnd_ops);
      int           g;
      int           c_now;
      int           idx;
      logic [N-1:0] exp_rdy;
      exp_t         e;
      @(negedge clk);
      reset     = rst_v;
      en        = en_v;
      req_valid = vld_v;
      if (rnd_ops) begin
         for (int i = 0; i < N; i++) begin
            req_op1[32*i +: 32] = {1'b0, 8'($urandom_range(100, 150)), 23'($urandom)};
            req_op2[32*i +: 32] = {1'($urandom), 8'($urandom_range(100, 150)), 23'($urandom)};
         end
      end
      c_now = cyc;
      #1;
      g = -1;
      if (!rst_v && en_v) begin
         for (int k = 1; k <= N; k++) begin
            idx = (m_ptr + k) % N;
            if (g < 0 && vld_v[idx]) g = idx;
         end
      end
      exp_rdy = '0;
      if (g >= 0) exp_rdy[g] = 1'b1;
      check("req_ready", 32'(req_ready), 32'(exp_rdy));
      check("issue_cnt", issue_cnt, m_cnt);
      @(posedge clk);
      if (rst_v) begin
         m_ptr = N - 1;
         m_cnt = '0;
         sb.delete();
      end else if (g >= 0) begin
         e.id   = g;
         e.data = fmul_fn(req_op1[32*g +: 32], req_op2[32*g +: 32]);
         e.due  = c_now + 1 + LAT;
         sb.push_back(e);
         m_ptr = g;
         m_cnt = m_cnt + 32'd1;
      end
   endtask

   // Monitor: every cycle, either the oldest expected response is due and
   // must appear, or resp_valid must be quiet.
   initial begin
      exp_t         e;
      logic [N-1:0] oh;
      forever begin
         @(negedge clk);
         #2;
         if (reset) begin
            check("resp_valid_in_reset", 32'(resp_valid), 32'd0);
            check("busy_in_reset", 32'(busy), 32'd0);
         end else begin
            check("busy", 32'(busy), 32'(sb.size() != 0));
            if (sb.size() > 0 && sb[0].due == cyc) begin
               e  = sb.pop_front();
               oh = '0;
               oh[e.id] = 1'b1;
               check("resp_valid", 32'(resp_valid), 32'(oh));
               check("resp_data", resp_data, e.data);
            end else begin
               check("resp_valid_idle", 32'(resp_valid), 32'd0);
            end
         end
      end
   end

   initial begin
      repeat (3) drive(1'b1, 1'b0, 4'b0000, 1'b1);

      // Single op: 1.5 * 2.0 from requester 0.
      req_op1[31:0] = 32'h3FC0_0000;
      req_op2[31:0] = 32'h4000_0000;
      drive(1'b0, 1'b1, 4'b0001, 1'b0);
      check("single_product", fmul_fn(32'h3FC0_0000, 32'h4000_0000), 32'h4040_0000);
      repeat (5) drive(1'b0, 1'b1, 4'b0000, 1'b1);

      // Fairness from a fresh reset: grants 0,1,2,3,0,1,2,3.
      drive(1'b1, 1'b1, 4'b1111, 1'b1);
      repeat (8) drive(1'b0, 1'b1, 4'b1111, 1'b1);
      repeat (5) drive(1'b0, 1'b1, 4'b0000, 1'b1);

      // Throughput: requester 2 alone.
      repeat (10) drive(1'b0, 1'b1, 4'b0100, 1'b1);
      repeat (5) drive(1'b0, 1'b1, 4'b0000, 1'b1);

      // Enable drop with 3 ops in flight, then resume.
      repeat (3) drive(1'b0, 1'b1, 4'b1111, 1'b1);
      repeat (6) drive(1'b0, 1'b0, 4'b1111, 1'b1);
      repeat (3) drive(1'b0, 1'b1, 4'b1111, 1'b1);
      repeat (5) drive(1'b0, 1'b1, 4'b0000, 1'b1);

      // Reset mid-flight, then 0 and 3 contend.
      repeat (2) drive(1'b0, 1'b1, 4'b1001, 1'b1);
      drive(1'b1, 1'b1, 4'b1001, 1'b1);
      repeat (2) drive(1'b0, 1'b1, 4'b1001, 1'b1);
      repeat (5) drive(1'b0, 1'b1, 4'b0000, 1'b1);

      // Randomized traffic.
      for (int n = 0; n < 150; n++) begin
         drive(1'($urandom_range(39) == 0), 1'($urandom_range(4) != 0), 4'($urandom), 1'b1);
      end
      repeat (5) drive(1'b0, 1'b1, 4'b0000, 1'b1);

      // Counter wrap.
      #1;
      force dut.r_issue_cnt = 32'hFFFF_FFFE;
      m_cnt = 32'hFFFF_FFFE;
      #1;
      release dut.r_issue_cnt;
      repeat (2) drive(1'b0, 1'b1, 4'b0001, 1'b1);
      repeat (6) drive(1'b0, 1'b1, 4'b0000, 1'b1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
`default_nettype wire
